lane_egress_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one w-bit transceiver egress lane among R requester streams (AXI-Stream-like valid/ready/last) ahead of the lane's out FIFO. A grant is held for a whole packet. Grants are only issued while the lane's link is up. Packets are force-terminated after MAX_BEATS beats, and a packet in flight is flushed if the link drops.

---
 rtl/lane_egress_arbiter.sv | 155 +++++++++++++++
 tb/tb_lane_egress_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_egress_arbiter.sv
// Packet-level round-robin arbiter sharing one transceiver egress lane among R streams.
// A grant covers a whole packet; overlong packets are cut and link loss flushes the packet.
module lane_egress_arbiter #(
  parameter int R         = 4,
  parameter int w         = 128,
  parameter int MAX_BEATS = 256
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           link_up,
  input  logic [R-1:0]   req_valid,
  input  logic [w*R-1:0] req_data,
  input  logic [R-1:0]   req_last,
  output logic [R-1:0]   req_ready,
  output logic [w-1:0]   out_data,
  output logic           out_valid,
  output logic           out_last,
  input  logic           out_ready,
  output logic [R-1:0]   grant,
  output logic           timeout_err,
  output logic           flush_err,
  output logic [1:0]     dbg_state_o
);

  localparam int PW = $clog2(R);
  localparam int CW = $clog2(MAX_BEATS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e          state_q;
  logic [R-1:0]    grant_q;
  logic [PW-1:0]   owner_q;
  logic [PW-1:0]   rr_ptr_q;
  logic [CW-1:0]   beat_cnt_q;
  logic            quiet_flush_q;
  logic            timeout_err_q;
  logic            flush_err_q;

  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   scan_idx;
  logic            owner_last;
  logic            at_limit;
  logic            beat;
  logic            drop;

  // Round-robin scan starting just after the last completed owner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int i = 1; i <= R; i++) begin
      scan_idx = PW'((int'(rr_ptr_q) + i) % R);
      if (!pick_found && req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // Handshake: a beat moves on a rising edge where valid and ready are both high;
  // the lane's out_valid never depends on out_ready, and req_ready only on out_ready.
  always_comb begin
    out_data   = '0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    req_ready  = '0;
    beat       = 1'b0;
    drop       = 1'b0;
    owner_last = req_last[owner_q];
    at_limit   = (beat_cnt_q == CW'(MAX_BEATS - 1));
    case (state_q)
      ST_BUSY: begin
        out_data           = req_data[int'(owner_q)*w +: w];
        out_valid          = req_valid[owner_q];
        out_last           = owner_last | at_limit;
        req_ready[owner_q] = out_ready;
        beat               = req_valid[owner_q] & out_ready;
      end
      ST_FLUSH: begin
        req_ready[owner_q] = 1'b1;
        drop               = req_valid[owner_q];
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      rr_ptr_q      <= PW'(R - 1);
      beat_cnt_q    <= '0;
      quiet_flush_q <= 1'b0;
      timeout_err_q <= 1'b0;
      flush_err_q   <= 1'b0;
    end else begin
      timeout_err_q <= 1'b0;
      flush_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (link_up && pick_found) begin
            state_q    <= ST_BUSY;
            owner_q    <= pick_idx;
            grant_q    <= {{(R-1){1'b0}}, 1'b1} << pick_idx;
            beat_cnt_q <= '0;
          end
        end
        ST_BUSY: begin
          if (beat && owner_last) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= owner_q;
            beat_cnt_q <= '0;
          end else if (beat && at_limit) begin
            // Counter holds at its limit; the rest of the packet is dropped silently.
            state_q       <= ST_FLUSH;
            timeout_err_q <= 1'b1;
            quiet_flush_q <= 1'b1;
          end else begin
            if (beat) begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
            if (!link_up) begin
              state_q       <= ST_FLUSH;
              quiet_flush_q <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          if (drop && owner_last) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= owner_q;
            beat_cnt_q  <= '0;
            flush_err_q <= !quiet_flush_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign timeout_err = timeout_err_q;
  assign flush_err   = flush_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lane_egress_arbiter.sv
// Scoreboard bench for lane_egress_arbiter: per-requester beat sources feed the DUT,
// expected lane beats are queued as packets are built and popped as the lane emits them.
module tb_lane_egress_arbiter;

  localparam int RR   = 4;
  localparam int W    = 16;
  localparam int MAXB = 4;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            link_up;
  logic [RR-1:0]   req_valid, req_last, req_ready, grant;
  logic [W*RR-1:0] req_data;
  logic [W-1:0]    out_data;
  logic            out_valid, out_last, out_ready;
  logic            timeout_err, flush_err;
  logic [1:0]      dbg_state;

  lane_egress_arbiter #(.R(RR), .w(W), .MAX_BEATS(MAXB)) dut (
    .clock       (clk),
    .reset       (rst),
    .link_up     (link_up),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .grant       (grant),
    .timeout_err (timeout_err),
    .flush_err   (flush_err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W:0]    src_q [RR][$];
  logic [W:0]    exp_q[$];
  logic [RR-1:0] grant_log[$];
  logic [RR-1:0] prev_grant;
  logic [RR-1:0] t2_order [5];

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   first_beat, last_beat;
  int   tcnt, fcnt;
  int   ready_mode;
  logic ready_phase;
  bit   chk_mirror;
  logic [RR-1:0] obs_grant;
  logic [1:0]    obs_state;
  logic          obs_valid;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pending();
    int n = exp_q.size();
    for (int g = 0; g < RR; g++) n += src_q[g].size();
    return n;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_pkt(input int g, input int n, input int keep);
    logic [W:0] ent;
    for (int i = 0; i < n; i++) begin
      ent[W-1:0] = W'($urandom_range(0, 65535));
      ent[W]     = (i == n - 1);
      src_q[g].push_back(ent);
      if (i < keep) exp_q.push_back({ent[W] | (i == MAXB - 1), ent[W-1:0]});
    end
  endtask

  task automatic drive_inputs();
    logic [W:0] ent;
    for (int g = 0; g < RR; g++) begin
      if (src_q[g].size() > 0) begin
        ent = src_q[g][0];
        req_valid[g]         = 1'b1;
        req_data[g*W +: W]   = ent[W-1:0];
        req_last[g]          = ent[W];
      end else begin
        req_valid[g]         = 1'b0;
        req_data[g*W +: W]   = W'($urandom_range(0, 65535));
        req_last[g]          = 1'($urandom_range(0, 1));
      end
    end
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready   = ready_phase;
        ready_phase = ~ready_phase;
      end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic observe();
    logic [W:0] ent;
    logic [W:0] gone;
    obs_grant = grant;
    obs_state = dbg_state;
    obs_valid = out_valid;
    check("grant_onehot0", $onehot0(grant), 1'b1);
    check("ready_owner_only", req_ready & ~grant, '0);
    if (dbg_state != S_BUSY) check("valid_outside_busy", out_valid, 1'b0);
    if (dbg_state == S_IDLE) check("idle_grant_zero", grant, '0);
    if (dbg_state == S_FLUSH) check("flush_ready", req_ready, grant);
    if (chk_mirror && dbg_state == S_BUSY) check("ready_mirror", req_ready[1], out_ready);
    if (out_valid && out_ready) begin
      if (first_beat < 0) first_beat = cyc;
      last_beat = cyc;
      if (exp_q.size() == 0) begin
        check("lane_extra_beat", exp_q.size(), 1);
      end else begin
        ent = exp_q.pop_front();
        check("lane_beat", {out_last, out_data}, ent);
      end
    end
    for (int g = 0; g < RR; g++) begin
      if (req_valid[g] && req_ready[g] && src_q[g].size() > 0) gone = src_q[g].pop_front();
    end
    tcnt += int'(timeout_err);
    fcnt += int'(flush_err);
    if (grant != '0 && grant != prev_grant) grant_log.push_back(grant);
    prev_grant = grant;
  endtask

  // Called on a falling edge: drive, sample just before the rising edge, return on the next fall.
  task automatic cycle();
    drive_inputs();
    #4;
    observe();
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (pending() != 0 && n < 200) begin
      cycle();
      n++;
    end
    check(tag, pending(), 0);
    cycle();
    cycle();
  endtask

  task automatic clear_all();
    for (int g = 0; g < RR; g++) src_q[g].delete();
    exp_q.delete();
    grant_log.delete();
    prev_grant = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_all();
    drive_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; link_up = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
    out_ready = 1'b1; ready_mode = 0; ready_phase = 1'b1; chk_mirror = 1'b0;
    prev_grant = '0; first_beat = -1; last_beat = -1; tcnt = 0; fcnt = 0;
    t2_order[0] = 4'b0001; t2_order[1] = 4'b0010; t2_order[2] = 4'b0100;
    t2_order[3] = 4'b1000; t2_order[4] = 4'b0001;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_grant", grant, '0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_req_ready", req_ready, '0);
    check("rst_errs", {timeout_err, flush_err}, 2'b00);
    check("rst_state", dbg_state, S_IDLE);
    @(negedge clk);

    // Single 3-beat packet from requester 0.
    push_pkt(0, 3, 3);
    cycle();
    check("t1_no_grant_yet", obs_grant, '0);
    cycle();
    check("t1_grant", obs_grant, 4'b0001);
    check("t1_first_beat_valid", obs_valid, 1'b1);
    cycle();
    cycle();
    cycle();
    check("t1_idle_after", obs_state, S_IDLE);
    check("t1_drained", pending(), 0);
    // rr_ptr now points at 0, so requester 1 wins a tie against 0.
    grant_log.delete();
    push_pkt(1, 1, 1);
    push_pkt(0, 1, 1);
    drain("t1_tie_drain");
    check("t1_tie_first", grant_log.size() > 0 ? grant_log[0] : '0, 4'b0001 << 1);

    // All four requesters with 2-beat packets; requester 0 has a second packet.
    apply_reset();
    first_beat = -1;
    push_pkt(0, 2, 2);
    push_pkt(1, 2, 2);
    push_pkt(2, 2, 2);
    push_pkt(3, 2, 2);
    push_pkt(0, 2, 2);
    drain("t2_drain");
    check("t2_grant_count", grant_log.size(), 5);
    for (int i = 0; i < 5; i++)
      check("t2_grant_order", (i < grant_log.size()) ? grant_log[i] : '0, t2_order[i]);
    check("t2_span", last_beat - first_beat, 13);

    // Requester 1 with a toggling out_ready.
    ready_mode = 1; ready_phase = 1'b1; chk_mirror = 1'b1;
    push_pkt(1, 4, 4);
    drain("t3_drain");
    ready_mode = 0; chk_mirror = 1'b0;

    // Oversize packet from requester 2 is cut after MAXB beats.
    tcnt = 0; fcnt = 0;
    push_pkt(2, 6, MAXB);
    drain("t4_drain");
    check("t4_timeout_pulses", tcnt, 1);
    check("t4_no_flush_err", fcnt, 0);
    check("t4_idle", obs_state, S_IDLE);

    // Link drops on beat 2 of a 5-beat packet from requester 3.
    tcnt = 0; fcnt = 0;
    push_pkt(3, 5, 2);
    cycle();
    cycle();
    link_up = 1'b0;
    cycle();
    cycle();
    check("t5_flush_state", obs_state, S_FLUSH);
    check("t5_flush_no_valid", obs_valid, 1'b0);
    cycle();
    cycle();
    cycle();
    check("t5_idle_after_flush", obs_state, S_IDLE);
    push_pkt(0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t5_no_grant_link_down", obs_grant, '0);
    end
    check("t5_flush_pulses", fcnt, 1);
    check("t5_no_timeout", tcnt, 0);
    link_up = 1'b1;
    drain("t5_drain");

    // Reset in the middle of a packet.
    push_pkt(1, 4, 4);
    cycle();
    cycle();
    cycle();
    check("t6_busy_before_reset", obs_state, S_BUSY);
    rst = 1'b1;
    #1;
    check("t6_rst_grant", grant, '0);
    check("t6_rst_valid", out_valid, 1'b0);
    check("t6_rst_ready", req_ready, '0);
    check("t6_rst_state", dbg_state, S_IDLE);
    clear_all();
    drive_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_pkt(0, 1, 1);
    push_pkt(3, 1, 1);
    drain("t6_drain");
    check("t6_tie_count", grant_log.size(), 2);
    check("t6_tie_winner", grant_log.size() > 0 ? grant_log[0] : '0, 4'b0001);

    // Random out_ready with a few random-length packets from requester 2.
    ready_mode = 2;
    for (int i = 0; i < 3; i++) push_pkt(2, $urandom_range(1, MAXB), MAXB);
    drain("t7_drain");
    ready_mode = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
